uart_apb_master: RTL and testbench
==================================

// Module: uart_apb_master
// PURPOSE
//  APB initiator for the UART register slave: turns single-beat requests from local logic into
//  APB SETUP/ACCESS transfers on PSEL/PENABLE/PADDR/PWRITE/PWDATA, waits on PREADY, returns
//  PRDATA or a timeout error. Sits between a command sequencer and the UART APB slave port.
// PARAMETERS
//  ADDR_W      2    APB address width (UART register select)
//  DATA_W      8    APB data width (matches `BITWIDTH)
//  TIMEOUT     16   max ACCESS cycles with PREADY=0 before abort; 0 = wait forever
// PORTS
//  PCLK        in   1       clock; all logic rising-edge
//  PRESET      in   1       synchronous reset, active-high
//  req_valid   in   1       request present
//  req_ready   out  1       block accepts request (IDLE only)
//  req_write   in   1       1 = write, 0 = read
//  req_addr    in   ADDR_W  target register
//  req_wdata   in   DATA_W  write data
//  rsp_valid   out  1       one-cycle response strobe
//  rsp_rdata   out  DATA_W  read data (0 for writes and errors)
//  rsp_err     out  1       transfer aborted by timeout (valid with rsp_valid)
//  busy        out  1       transfer in progress (SETUP or ACCESS)
//  PSEL        out  1       APB select
//  PENABLE     out  1       APB enable
//  PADDR       out  ADDR_W  APB address
//  PWRITE      out  1       APB direction
//  PWDATA      out  DATA_W  APB write data
//  PRDATA      in   DATA_W  APB read data
//  PREADY      in   1       APB ready from slave
// BEHAVIOUR
//  - Reset (PRESET=1 at edge): state IDLE; every output 0 except req_ready=1; timeout counter 0.
//    Reset mid-transfer aborts immediately, drops PSEL/PENABLE next edge, no rsp_valid issued.
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. All outputs registered.
//  - IDLE: req_ready=1. Handshake req_valid&req_ready at edge N latches write/addr/wdata -> SETUP.
//  - SETUP (cycle N+1): PSEL=1, PENABLE=0, PADDR/PWRITE driven from latch; PWDATA=wdata on
//    write, 0 on read. Unconditionally -> ACCESS.
//  - ACCESS (cycle N+2..): PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable.
//    PREADY=1 at edge: capture PRDATA (reads) -> IDLE; next cycle rsp_valid=1 for exactly one cycle,
//    rsp_err=0, PSEL=PENABLE=0. Zero-wait transfer: request to rsp_valid = 3 cycles.
//    PREADY=0: counter++; when counter==TIMEOUT (TIMEOUT!=0) -> IDLE with rsp_valid=1, rsp_err=1,
//    rsp_rdata=0. Counter cleared on entry to SETUP. PREADY ignored outside ACCESS.
//  - rsp_rdata holds until next rsp_valid; rsp_err cleared on next accepted request.
//  - Back-to-back: req_ready is 1 in the same cycle rsp_valid=1; new request accepted there
//    enters SETUP next cycle (PSEL low for exactly one cycle between transfers).
//  - busy = (state != IDLE). req_ready = ~busy.
//  - Counter width clog2(TIMEOUT+1); saturates, never wraps.
// TESTING
//  1 write addr=2'b01 data=8'hA5, PREADY tied 1 -> SETUP at N+1, ACCESS N+2 with PWDATA=A5,
//    rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
//  2 read addr=2'b10, PREADY low 4 ACCESS cycles then high with PRDATA=8'h3C -> PENABLE high
//    5 cycles, PADDR stable, rsp_rdata=3C, rsp_valid single pulse.
//  3 TIMEOUT=16, PREADY held 0 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0,
//    PSEL low next cycle; following request completes normally with rsp_err=0.
//  4 req_valid held high with two queued writes (8'h11, 8'h22) -> second SETUP one cycle after
//    first rsp_valid; PSEL low exactly one cycle between; data order preserved.
//  5 PRESET asserted in ACCESS with PREADY=0 -> next cycle PSEL=PENABLE=0, busy=0, req_ready=1,
//    no rsp_valid; PREADY pulse afterwards produces no response.
//  6 PREADY=1 and PRDATA=8'hFF during IDLE/SETUP -> no early completion, rsp_rdata unchanged.

Source files
------------

// File: rtl/uart_apb_master.sv
// APB initiator for the UART register slave.
// Single-beat local requests become APB SETUP/ACCESS transfers with a PREADY timeout.
module uart_apb_master #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_V = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             expired;

    // Saturating increment so a wait-forever transfer never wraps the counter.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    assign expired = (TIMEOUT != 0) && (cnt_inc == TO_V);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        state     <= SETUP;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        rsp_err   <= 1'b0;
                        PSEL      <= 1'b1;
                        PENABLE   <= 1'b0;
                        PADDR     <= req_addr;
                        PWRITE    <= req_write;
                        PWDATA    <= req_write ? req_wdata : '0;
                    end
                end
                SETUP: begin
                    state   <= ACCESS;
                    PENABLE <= 1'b1;
                end
                ACCESS: begin
                    if (PREADY || expired) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= ~PREADY;
                        rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : '0;
                        PSEL      <= 1'b0;
                        PENABLE   <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_apb_master.sv
// Directed bench for uart_apb_master: timing, wait states, timeout,
// back-to-back requests, reset abort and PREADY outside ACCESS.
module tb_uart_apb_master;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [1:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       PSEL;
    logic       PENABLE;
    logic [1:0] PADDR;
    logic       PWRITE;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    int errors = 0;
    int checks = 0;

    uart_apb_master #(
        .ADDR_W (2),
        .DATA_W (8),
        .TIMEOUT(16)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .busy     (busy),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs checked 1ns after the edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic request(input logic w, input logic [1:0] a,
                           input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    int n;

    initial begin
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        tick();
        tick();
        PRESET = 1'b0;

        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_pen", PENABLE, 0);
        chk("rst_rvalid", rsp_valid, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_pwdata", PWDATA, 0);

        // 1: zero-wait write
        request(1'b1, 2'b01, 8'hA5);
        chk("t1_setup_psel", PSEL, 1);
        chk("t1_setup_pen", PENABLE, 0);
        chk("t1_setup_paddr", PADDR, 2'b01);
        chk("t1_setup_pwrite", PWRITE, 1);
        chk("t1_setup_pwdata", PWDATA, 8'hA5);
        chk("t1_setup_busy", busy, 1);
        chk("t1_setup_ready", req_ready, 0);
        tick();
        chk("t1_acc_psel", PSEL, 1);
        chk("t1_acc_pen", PENABLE, 1);
        chk("t1_acc_pwdata", PWDATA, 8'hA5);
        chk("t1_acc_rvalid", rsp_valid, 0);
        tick();
        chk("t1_rvalid", rsp_valid, 1);
        chk("t1_err", rsp_err, 0);
        chk("t1_rdata", rsp_rdata, 0);
        chk("t1_psel_low", PSEL, 0);
        chk("t1_ready", req_ready, 1);
        tick();
        chk("t1_rvalid_pulse", rsp_valid, 0);

        // 6: PREADY/PRDATA active outside ACCESS
        PRDATA = 8'hFF;
        PREADY = 1'b1;
        tick();
        chk("t6_idle_rvalid", rsp_valid, 0);
        chk("t6_idle_rdata", rsp_rdata, 0);
        request(1'b0, 2'b11, 8'h00);
        chk("t6_setup_pen", PENABLE, 0);
        chk("t6_setup_pwdata", PWDATA, 0);
        tick();
        chk("t6_acc_pen", PENABLE, 1);
        chk("t6_acc_rvalid", rsp_valid, 0);
        chk("t6_acc_rdata", rsp_rdata, 0);
        PRDATA = 8'h5A;
        tick();
        chk("t6_rvalid", rsp_valid, 1);
        chk("t6_rdata", rsp_rdata, 8'h5A);

        // 2: read with four wait states
        PREADY = 1'b0;
        PRDATA = 8'h00;
        request(1'b0, 2'b10, 8'h00);
        tick();
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (PENABLE) n++;
            chk("t2_wait_paddr", PADDR, 2'b10);
            chk("t2_wait_rvalid", rsp_valid, 0);
            tick();
        end
        PREADY = 1'b1;
        PRDATA = 8'h3C;
        if (PENABLE) n++;
        chk("t2_last_paddr", PADDR, 2'b10);
        tick();
        PREADY = 1'b0;
        chk("t2_pen_cycles", n, 5);
        chk("t2_rvalid", rsp_valid, 1);
        chk("t2_rdata", rsp_rdata, 8'h3C);
        chk("t2_err", rsp_err, 0);
        tick();
        chk("t2_rvalid_pulse", rsp_valid, 0);
        chk("t2_rdata_hold", rsp_rdata, 8'h3C);

        // 3: timeout abort, then a normal transfer
        PRDATA = 8'h77;
        request(1'b0, 2'b00, 8'h00);
        tick();
        n = 0;
        while (PENABLE && n < 40) begin
            n++;
            tick();
        end
        chk("t3_acc_cycles", n, 16);
        chk("t3_rvalid", rsp_valid, 1);
        chk("t3_err", rsp_err, 1);
        chk("t3_rdata", rsp_rdata, 0);
        chk("t3_psel_low", PSEL, 0);
        tick();
        chk("t3_err_hold", rsp_err, 1);
        PREADY = 1'b1;
        PRDATA = 8'hC3;
        request(1'b0, 2'b01, 8'h00);
        chk("t3_err_clr", rsp_err, 0);
        tick();
        tick();
        chk("t3b_rvalid", rsp_valid, 1);
        chk("t3b_err", rsp_err, 0);
        chk("t3b_rdata", rsp_rdata, 8'hC3);

        // 4: back-to-back writes with req_valid held high
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 2'b11;
        req_wdata = 8'h11;
        tick();
        req_wdata = 8'h22;
        chk("t4_a_setup_pwdata", PWDATA, 8'h11);
        tick();
        chk("t4_a_acc_pwdata", PWDATA, 8'h11);
        tick();
        chk("t4_a_rvalid", rsp_valid, 1);
        chk("t4_gap_psel", PSEL, 0);
        chk("t4_gap_ready", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("t4_b_psel", PSEL, 1);
        chk("t4_b_pen", PENABLE, 0);
        chk("t4_b_pwdata", PWDATA, 8'h22);
        tick();
        tick();
        chk("t4_b_rvalid", rsp_valid, 1);
        tick();

        // 5: reset during ACCESS
        PREADY = 1'b0;
        request(1'b0, 2'b10, 8'h00);
        tick();
        tick();
        chk("t5_in_access", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("t5_psel", PSEL, 0);
        chk("t5_pen", PENABLE, 0);
        chk("t5_busy", busy, 0);
        chk("t5_ready", req_ready, 1);
        chk("t5_rvalid", rsp_valid, 0);
        PREADY = 1'b1;
        PRDATA = 8'h99;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid || PSEL) n++;
        end
        chk("t5_no_rsp", n, 0);
        chk("t5_rdata", rsp_rdata, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
